// File: rtl/rom_bus_controller.sv
// ROM-side sequencer for the 4-bit multiplexed CPU bus: follows the 8-phase frame, fetches a byte
// from the attached ROM, drives the opcode nibbles back, and services SRC/WRR/RDR on its I/O port.
module rom_bus_controller #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] data_i,
  output logic [3:0] data_o,
  output logic       data_en,
  input  logic       sync,
  input  logic       rom_cmd,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [7:0] mem_data,
  input  logic [3:0] io_in,
  output logic [3:0] io_out
);

  typedef enum logic [2:0] {
    PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
  } phase_e;

  phase_e     phase_q, phase_d;
  logic       synced_q;
  logic [7:0] addr_q;
  logic       sel_q;
  logic [7:0] byte_q;
  logic [3:0] opr_q;
  logic [3:0] opa_q;
  logic       io_op_q;
  logic       src_match_q;
  logic [3:0] io_out_q;

  logic chip_hit;
  logic rd_now;
  logic io_x2;
  logic rdr_now;
  logic wrr_now;

  assign chip_hit = (data_i == CHIP_ID);
  assign rd_now   = synced_q && (phase_q == PH_A3) && chip_hit;
  // I/O decisions use the src_match held before any SRC landing in this same X2
  assign io_x2    = synced_q && (phase_q == PH_X2) && io_op_q && src_match_q;
  assign rdr_now  = io_x2 && (opa_q == 4'hA);
  assign wrr_now  = io_x2 && (opa_q == 4'h2);

  assign mem_rd   = rd_now;
  assign mem_addr = (synced_q && (phase_q == PH_A3)) ? addr_q : 8'h00;
  assign io_out   = io_out_q;

  always_comb begin
    data_en = 1'b0;
    data_o  = 4'h0;
    if (synced_q) begin
      case (phase_q)
        PH_M1: if (sel_q) begin
          data_en = 1'b1;
          data_o  = mem_data[7:4];
        end
        PH_M2: if (sel_q) begin
          data_en = 1'b1;
          data_o  = byte_q[3:0];
        end
        PH_X2: if (rdr_now) begin
          data_en = 1'b1;
          data_o  = io_in;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (sync) begin
      phase_d = PH_A1;
    end else if (synced_q) begin
      phase_d = phase_e'(phase_q + 3'd1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q     <= PH_A1;
      synced_q    <= 1'b0;
      addr_q      <= 8'h00;
      sel_q       <= 1'b0;
      byte_q      <= 8'h00;
      opr_q       <= 4'h0;
      opa_q       <= 4'h0;
      io_op_q     <= 1'b0;
      src_match_q <= 1'b0;
      io_out_q    <= 4'h0;
    end else begin
      phase_q <= phase_d;
      // A sync abandons the current frame: no end-of-phase action is taken this cycle
      if (sync) begin
        synced_q <= 1'b1;
        sel_q    <= 1'b0;
        io_op_q  <= 1'b0;
      end else if (synced_q) begin
        case (phase_q)
          PH_A1: addr_q[3:0] <= data_i;
          PH_A2: addr_q[7:4] <= data_i;
          PH_A3: sel_q <= rd_now;
          PH_M1: begin
            opr_q <= data_i;
            if (sel_q) byte_q <= mem_data;
          end
          PH_M2: begin
            opa_q   <= data_i;
            io_op_q <= rom_cmd && (opr_q == 4'hE);
          end
          PH_X2: begin
            if (wrr_now) io_out_q <= data_i;
            if (rom_cmd) src_match_q <= chip_hit;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_bus_controller.sv
// Scoreboarded bench: each driven cycle queues its expected bus/ROM outputs, a negedge monitor pops and compares.
module tb_rom_bus_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] data_i;
  logic [3:0] data_o;
  logic       data_en;
  logic       sync = 1'b0;
  logic       rom_cmd = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data = 8'h00;
  logic [3:0] io_in = 4'h0;
  logic [3:0] io_out;
  logic [3:0] tb_bus = 4'h0;

  logic [7:0] rom [256];

  typedef struct packed {
    logic       en;
    logic [3:0] dout;
    logic       rd;
    logic [7:0] addr;
  } exp_t;

  exp_t  exq [$];
  string tagq [$];
  int    n_chk = 0;
  int    n_err = 0;

  rom_bus_controller #(.CHIP_ID(4'h0)) dut (
    .clock    (clock),
    .reset    (reset),
    .data_i   (data_i),
    .data_o   (data_o),
    .data_en  (data_en),
    .sync     (sync),
    .rom_cmd  (rom_cmd),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .io_in    (io_in),
    .io_out   (io_out)
  );

  // Resolved bus: the DUT wins whenever it drives, otherwise the bench's CPU/other-chip value
  assign data_i = data_en ? data_o : tb_bus;

  always #5 clock = ~clock;

  always @(posedge clock) if (mem_rd) mem_data <= rom[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (exq.size() > 0) begin
      exp_t  e;
      string t;
      e = exq.pop_front();
      t = tagq.pop_front();
      chk({t, ".en"},   32'(data_en),  32'(e.en));
      chk({t, ".do"},   32'(data_o),   32'(e.dout));
      chk({t, ".rd"},   32'(mem_rd),   32'(e.rd));
      chk({t, ".addr"}, 32'(mem_addr), 32'(e.addr));
    end
  end

  function automatic exp_t mk(input logic en, input logic [3:0] dout, input logic rd, input logic [7:0] addr);
    exp_t e;
    e.en   = en;
    e.dout = dout;
    e.rd   = rd;
    e.addr = addr;
    return e;
  endfunction

  task automatic cyc(input logic s, input logic rc, input logic [3:0] bus, input exp_t e, input string tag);
    sync    = s;
    rom_cmd = rc;
    tb_bus  = bus;
    exq.push_back(e);
    tagq.push_back(tag);
    @(posedge clock);
    #1;
  endtask

  task automatic body(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                      input logic [3:0] m1, input logic [3:0] m2,
                      input logic rc_m2, input logic rc_x2, input logic [3:0] x2,
                      input logic sel, input logic rdr, input logic [3:0] rdrv, input string t);
    logic [7:0] b;
    logic [3:0] hi;
    logic [3:0] lo;
    b  = rom[{a2, a1}];
    hi = sel ? b[7:4] : 4'h0;
    lo = sel ? b[3:0] : 4'h0;
    cyc(1'b0, 1'b0, a1, mk(1'b0, 4'h0, 1'b0, 8'h00), {t, ".A1"});
    cyc(1'b0, 1'b0, a2, mk(1'b0, 4'h0, 1'b0, 8'h00), {t, ".A2"});
    cyc(1'b0, 1'b0, a3, mk(1'b0, 4'h0, sel, {a2, a1}), {t, ".A3"});
    cyc(1'b0, 1'b0, m1, mk(sel, hi, 1'b0, 8'h00), {t, ".M1"});
    cyc(1'b0, rc_m2, m2, mk(sel, lo, 1'b0, 8'h00), {t, ".M2"});
    cyc(1'b0, 1'b0, 4'h0, mk(1'b0, 4'h0, 1'b0, 8'h00), {t, ".X1"});
    cyc(1'b0, rc_x2, x2, mk(rdr, rdr ? rdrv : 4'h0, 1'b0, 8'h00), {t, ".X2"});
  endtask

  task automatic frame(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                       input logic [3:0] m1, input logic [3:0] m2,
                       input logic rc_m2, input logic rc_x2, input logic [3:0] x2,
                       input logic sel, input logic rdr, input logic [3:0] rdrv, input string t);
    cyc(1'b1, 1'b0, 4'h0, mk(1'b0, 4'h0, 1'b0, 8'h00), {t, ".SY"});
    body(a1, a2, a3, m1, m2, rc_m2, rc_x2, x2, sel, rdr, rdrv, t);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i * 7 + 3);
    rom[8'h34] = 8'hD7;
    rom[8'h5A] = 8'hEA;
    rom[8'h21] = 8'h6C;

    #1 reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst.en",   32'(data_en),  32'h0);
    chk("rst.do",   32'(data_o),   32'h0);
    chk("rst.rd",   32'(mem_rd),   32'h0);
    chk("rst.addr", 32'(mem_addr), 32'h0);
    chk("rst.io",   32'(io_out),   32'h0);
    reset = 1'b0;

    // Unsynced: idle cycles never drive or read, even with a matching chip nibble on the bus
    cyc(1'b0, 1'b0, 4'h0, mk(1'b0, 4'h0, 1'b0, 8'h00), "idle0");
    cyc(1'b0, 1'b0, 4'h0, mk(1'b0, 4'h0, 1'b0, 8'h00), "idle1");

    frame(4'h4, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, "fetch");
    frame(4'h4, 4'h3, 4'h1, 4'h3, 4'h4, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, "other");

    frame(4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, "src0");
    frame(4'h1, 4'h0, 4'h1, 4'hE, 4'h2, 1'b1, 1'b0, 4'h9, 1'b0, 1'b0, 4'h0, "wrr9");
    chk("io_wrr9", 32'(io_out), 32'h9);
    frame(4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 4'h0, "src5");
    frame(4'h1, 4'h0, 4'h1, 4'hE, 4'h2, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 4'h0, "wrr6");
    chk("io_unsel", 32'(io_out), 32'h9);
    // SRC and WRR in one frame: the write sees the old (non-matching) selection
    frame(4'h1, 4'h0, 4'h1, 4'hE, 4'h2, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, "wrrsrc");
    chk("io_same", 32'(io_out), 32'h9);
    frame(4'h1, 4'h0, 4'h1, 4'hE, 4'h2, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 4'h0, "wrr3");
    chk("io_wrr3", 32'(io_out), 32'h3);

    io_in = 4'hB;
    frame(4'h1, 4'h0, 4'h1, 4'hE, 4'hA, 1'b1, 1'b0, 4'h7, 1'b0, 1'b1, 4'hB, "rdr");
    frame(4'h1, 4'h0, 4'h1, 4'hE, 4'hA, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 4'h0, "rdr_nocmd");
    frame(4'h1, 4'h0, 4'h1, 4'hE, 4'h5, 1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 4'h0, "e5");
    chk("io_e5", 32'(io_out), 32'h3);
    io_in = 4'h6;
    frame(4'hA, 4'h5, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h7, 1'b1, 1'b1, 4'h6, "selrdr");

    // Resync during M1 of a selected fetch
    cyc(1'b1, 1'b0, 4'h0, mk(1'b0, 4'h0, 1'b0, 8'h00), "rs.SY");
    cyc(1'b0, 1'b0, 4'h1, mk(1'b0, 4'h0, 1'b0, 8'h00), "rs.A1");
    cyc(1'b0, 1'b0, 4'h2, mk(1'b0, 4'h0, 1'b0, 8'h00), "rs.A2");
    cyc(1'b0, 1'b0, 4'h0, mk(1'b0, 4'h0, 1'b1, 8'h21), "rs.A3");
    cyc(1'b1, 1'b0, 4'h0, mk(1'b1, 4'h6, 1'b0, 8'h00), "rs.M1sync");
    body(4'h4, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, "rs.next");

    // Asynchronous reset while driving in M2
    cyc(1'b1, 1'b0, 4'h0, mk(1'b0, 4'h0, 1'b0, 8'h00), "ar.SY");
    cyc(1'b0, 1'b0, 4'h1, mk(1'b0, 4'h0, 1'b0, 8'h00), "ar.A1");
    cyc(1'b0, 1'b0, 4'h2, mk(1'b0, 4'h0, 1'b0, 8'h00), "ar.A2");
    cyc(1'b0, 1'b0, 4'h0, mk(1'b0, 4'h0, 1'b1, 8'h21), "ar.A3");
    cyc(1'b0, 1'b0, 4'h0, mk(1'b1, 4'h6, 1'b0, 8'h00), "ar.M1");
    sync    = 1'b0;
    rom_cmd = 1'b0;
    tb_bus  = 4'h0;
    exq.push_back(mk(1'b1, 4'hC, 1'b0, 8'h00));
    tagq.push_back("ar.M2");
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("ar.en", 32'(data_en), 32'h0);
    chk("ar.do", 32'(data_o),  32'h0);
    chk("ar.io", 32'(io_out),  32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    cyc(1'b0, 1'b0, 4'h0, mk(1'b0, 4'h0, 1'b0, 8'h00), "ar.idle0");
    cyc(1'b0, 1'b0, 4'h0, mk(1'b0, 4'h0, 1'b0, 8'h00), "ar.idle1");
    cyc(1'b0, 1'b0, 4'h0, mk(1'b0, 4'h0, 1'b0, 8'h00), "ar.idle2");
    frame(4'h4, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, "ar.fetch");

    @(negedge clock);
    #1;
    chk("queue_drained", 32'(exq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rom_bus_controller.md
Name: rom_bus_controller

Overview:
- 4001-style ROM-side bus sequencer for the 4-bit multiplexed CPU bus.
- Tracks the 8-cycle instruction frame from `sync`, reassembles the 12-bit fetch address, and reads one byte from an attached synchronous ROM array.
- Drives the opcode nibbles back onto the bus and implements the SRC/WRR/RDR I/O port protocol under `rom_cmd`.
- One instance per ROM chip, distinguished by `CHIP_ID`; sits beside `cpu` on the shared bus.

Parameters:
- CHIP_ID, 4'h0, chip number matched against the A3 address nibble and the SRC chip nibble.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_i  input  4  resolved bus value.
- data_o  output  4  bus drive value; 4'h0 whenever data_en=0.
- data_en  output  1  bus drive enable.
- sync  input  1  frame marker from CPU.
- rom_cmd  input  1  CPU ROM command line.
- mem_addr  output  8  byte address into the local ROM array.
- mem_rd  output  1  one-cycle read strobe.
- mem_data  input  8  ROM byte; valid the cycle after mem_rd.
- io_in  input  4  I/O port input pins.
- io_out  output  4  I/O port output latch.

Behaviour:
- Reset (async): synced=0, phase=A1, data_en=0, data_o=0, mem_rd=0, mem_addr=0, io_out=0, src_match=0, addr/opcode latches=0.

Phase counter:
- Phases in order: A1, A2, A3, M1, M2, X1, X2, X3 (encoded 0..7).
- Any cycle with sync=1 loads phase=A1 for the next cycle and sets synced=1.
- Otherwise, when synced, phase increments mod 8 (X3 wraps to A1).
- sync mid-frame is a resync: the frame is abandoned, any in-progress fetch is dropped, and no drive occurs in the following M1/M2.
- While synced=0, the block never drives, reads or changes io_out.

Address capture:
- At end of A1, latch data_i into addr[3:0]; at end of A2, latch data_i into addr[7:4].
- In A3, mem_rd = (data_i == CHIP_ID) and mem_addr = addr[7:0]. This is combinational from data_i; mem_rd is high for only that one cycle.
- At end of A3, latch sel = mem_rd.

Opcode phases:
- M1: if sel, data_en=1 and data_o=mem_data[7:4]. At end of M1, latch byte=mem_data when sel.
- M2: if sel, data_en=1 and data_o=byte[3:0].
- All chips, selected or not, sample data_i at end of M1 into opr and at end of M2 into opa. This keeps opcode tracking independent of which chip drove the bus.
- At end of M2, io_op = rom_cmd & (opr==4'hE).

SRC handling:
- X2 with rom_cmd=1: latch src_match = (data_i == CHIP_ID).
- src_match persists across frames until the next SRC.
- If rom_cmd=1 in both M2 and X2 of the same frame, the SRC latch takes effect at end of X2, after the X2 I/O action has been evaluated with the old src_match.

I/O phase X2:
- WRR: io_op & opa==4'h2 & src_match → io_out <= data_i at end of X2.
- RDR: io_op & opa==4'hA & src_match → data_en=1, data_o=io_in during X2.
- Other opa values under E: no action by this block.

General drive rules:
- data_en is high only in M1/M2 (selected fetch) or X2 (RDR); otherwise 0.
- At most one drive source is active per cycle.
- Address arithmetic is 8 bits; no carry into the chip nibble, and wrap-around is the CPU's concern.
- Reset mid-frame: all outputs return to reset values immediately (async), and the block is unsynced until the next sync.

Test Plan:
1. Reset, sync, then A1..A3 = 4'h4, 4'h3, CHIP_ID=4'h0 with mem[8'h34]=8'hD7 → mem_rd=1 in A3 with mem_addr=8'h34; data_o=4'hD, data_en=1 in M1; data_o=4'h7 in M2; data_en=0 in every other phase.
2. Same frame with A3=4'h1 on a CHIP_ID=0 instance → mem_rd=0 and data_en=0 for the whole frame; opr/opa still capture the bus nibbles driven externally.
3. SRC frame: rom_cmd=1 in X2 with data_i=4'h0, then next frame M1/M2 bus=4'hE,4'h2, rom_cmd=1 in M2, data_i=4'h9 in X2 → io_out=4'h9. Repeat with SRC chip 4'h5 → io_out stays 4'h9.
4. RDR: src_match=1, io_in=4'hB, opcode E/A with rom_cmd in M2 → data_en=1, data_o=4'hB during X2 only.
5. Resync: sync asserted during M1 of a selected fetch → data_en drops to 0 from the next cycle; next phase=A1; the following frame fetches normally.
6. Reset asserted asynchronously mid-M2 while driving → data_en=0 and data_o=0 immediately, io_out=0; no drive until a new sync; the first full frame after sync fetches correctly.
